// File: rtl/grid_tick_scheduler.sv
// Two-player grid game sequencer: clears the grid, then on each tick marks both heads,
// probes the next cells and resolves collisions. Optional pause input via `GRID_SCHED_PAUSE_EN.
module grid_tick_scheduler #(
  parameter int TICK_CYCLES = 1000000,
  parameter int COLS        = 80,
  parameter int ROWS        = 60
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        reiniciar,
  input  logic        frame_blank,
`ifdef GRID_SCHED_PAUSE_EN
  input  logic        pause,
`endif
  input  logic [1:0]  dir1,
  input  logic [1:0]  dir2,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_wdata,
  input  logic [1:0]  mem_rdata,
  output logic [6:0]  pos1_col,
  output logic [5:0]  pos1_row,
  output logic [6:0]  pos2_col,
  output logic [5:0]  pos2_row,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        busy
);
  localparam int CW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [3:0] {
    S_CLEAR, S_WAIT, S_MARK1, S_MARK2, S_RD1, S_RD2, S_CAP2, S_RESOLVE, S_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [12:0]   clr_idx_q, clr_idx_d;
  logic [6:0]    clr_col_q, clr_col_d;
  logic [5:0]    clr_row_q, clr_row_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          pend_q, pend_d;
  logic          blank_q;
  logic [6:0]    p1c_q, p1c_d, p2c_q, p2c_d, n1c_q, n1c_d, n2c_q, n2c_d;
  logic [5:0]    p1r_q, p1r_d, p2r_q, p2r_d, n1r_q, n1r_d, n2r_q, n2r_d;
  logic [1:0]    cell1_q, cell1_d, cell2_q, cell2_d, winner_q, winner_d;
  logic [12:0]   addr_c;
  logic [1:0]    wdata_c;
  logic          we_c, run, wrap, border, hit1, hit2, same, hold_rst;

  function automatic logic [12:0] cell_addr(input logic [6:0] c, input logic [5:0] r);
    return 13'(int'(r) * COLS + int'(c));
  endfunction

  function automatic logic [12:0] step_head(input logic [6:0] c, input logic [5:0] r,
                                            input logic [1:0] d);
    logic [6:0] nc;
    logic [5:0] nr;
    nc = c;
    nr = r;
    case (d)
      2'd0:    nc = c + 7'd1;
      2'd1:    nr = r + 6'd1;
      2'd2:    nc = c - 7'd1;
      default: nr = r - 6'd1;
    endcase
    return {nc, nr};
  endfunction

  assign run = (state_q != S_CLEAR) && (state_q != S_OVER)
`ifdef GRID_SCHED_PAUSE_EN
               && !pause
`endif
               ;
  assign wrap   = run && (tick_q == CW'(TICK_CYCLES - 1));
  assign border = (clr_row_q < 6'd2) || (int'(clr_row_q) > ROWS - 3) ||
                  (clr_col_q < 7'd2) || (int'(clr_col_q) > COLS - 3);
  assign same   = (n1c_q == n2c_q) && (n1r_q == n2r_q);
  assign hit1   = (cell1_q != 2'd0) || same;
  assign hit2   = (cell2_q != 2'd0) || same;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    p1c_d = p1c_q;  p1r_d = p1r_q;  p2c_d = p2c_q;  p2r_d = p2r_q;
    n1c_d = n1c_q;  n1r_d = n1r_q;  n2c_d = n2c_q;  n2r_d = n2r_q;
    cell1_d  = cell1_q;
    cell2_d  = cell2_q;
    winner_d = winner_q;
    addr_c   = 13'd0;
    wdata_c  = 2'd0;
    we_c     = 1'b0;
    tick_d   = run ? (wrap ? '0 : tick_q + CW'(1)) : tick_q;
    pend_d   = wrap ? 1'b1 : ((state_q == S_WAIT) ? 1'b0 : pend_q);
    case (state_q)
      S_CLEAR: begin
        addr_c  = clr_idx_q;
        wdata_c = border ? 2'd3 : 2'd0;
        if (frame_blank) begin
          we_c = 1'b1;
          if (clr_idx_q == 13'(CELLS - 1)) begin
            state_d = S_WAIT;
          end else begin
            clr_idx_d = clr_idx_q + 13'd1;
            if (int'(clr_col_q) == COLS - 1) begin
              clr_col_d = 7'd0;
              clr_row_d = clr_row_q + 6'd1;
            end else begin
              clr_col_d = clr_col_q + 7'd1;
            end
          end
        end
      end
      S_WAIT: if (pend_q) begin
        {n1c_d, n1r_d} = step_head(p1c_q, p1r_q, dir1);
        {n2c_d, n2r_d} = step_head(p2c_q, p2r_q, dir2);
        state_d = S_MARK1;
      end
      S_MARK1: begin
        addr_c  = cell_addr(p1c_q, p1r_q);
        wdata_c = 2'd1;
        we_c    = frame_blank;
        if (frame_blank) state_d = S_MARK2;
      end
      S_MARK2: begin
        addr_c  = cell_addr(p2c_q, p2r_q);
        wdata_c = 2'd2;
        we_c    = frame_blank;
        if (frame_blank) state_d = S_RD1;
      end
      S_RD1: begin
        addr_c = cell_addr(n1c_q, n1r_q);
        if (frame_blank) state_d = S_RD2;
      end
      // read data is trusted only if the previous cycle owned the port; otherwise re-probe
      S_RD2: begin
        addr_c = cell_addr(n2c_q, n2r_q);
        if (frame_blank) begin
          if (blank_q) begin
            cell1_d = mem_rdata;
            state_d = S_CAP2;
          end else begin
            state_d = S_RD1;
          end
        end
      end
      S_CAP2: begin
        addr_c = cell_addr(n2c_q, n2r_q);
        if (frame_blank) begin
          if (blank_q) begin
            cell2_d = mem_rdata;
            state_d = S_RESOLVE;
          end else begin
            state_d = S_RD1;
          end
        end
      end
      S_RESOLVE: begin
        if (!hit1 && !hit2) begin
          p1c_d = n1c_q;  p1r_d = n1r_q;
          p2c_d = n2c_q;  p2r_d = n2r_q;
          state_d = S_WAIT;
        end else begin
          winner_d = (hit1 && hit2) ? 2'd3 : (hit1 ? 2'd2 : 2'd1);
          state_d  = S_OVER;
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciar) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= 13'd0;
      clr_col_q <= 7'd0;
      clr_row_q <= 6'd0;
      tick_q    <= '0;
      pend_q    <= 1'b0;
      blank_q   <= 1'b0;
      p1c_q <= 7'd27;  p1r_q <= 6'd30;
      p2c_q <= 7'd52;  p2r_q <= 6'd30;
      n1c_q <= 7'd0;   n1r_q <= 6'd0;
      n2c_q <= 7'd0;   n2r_q <= 6'd0;
      cell1_q  <= 2'd0;
      cell2_q  <= 2'd0;
      winner_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      blank_q   <= frame_blank;
      p1c_q <= p1c_d;  p1r_q <= p1r_d;
      p2c_q <= p2c_d;  p2r_q <= p2r_d;
      n1c_q <= n1c_d;  n1r_q <= n1r_d;
      n2c_q <= n2c_d;  n2r_q <= n2r_d;
      cell1_q  <= cell1_d;
      cell2_q  <= cell2_d;
      winner_q <= winner_d;
    end
  end

  // a restart request silences the grid port in the very cycle it is raised
  assign hold_rst  = reset | reiniciar;
  assign mem_we    = we_c & ~hold_rst;
  assign mem_wdata = mem_we ? wdata_c : 2'd0;
  assign mem_addr  = hold_rst ? 13'd0 : addr_c;
  assign pos1_col  = p1c_q;
  assign pos1_row  = p1r_q;
  assign pos2_col  = p2c_q;
  assign pos2_row  = p2r_q;
  assign winner    = winner_q;
  assign game_over = (state_q == S_OVER);
  assign busy      = (state_q != S_WAIT) && (state_q != S_OVER);

endmodule

// File: tb/tb_grid_tick_scheduler.sv
// Scoreboard bench for grid_tick_scheduler: expected grid writes are queued by the
// stimulus thread and popped by an independent write monitor.
`timescale 1ns/1ps
module tb_grid_tick_scheduler;
  localparam int TICK = 16;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1, reiniciar = 1'b0, frame_blank = 1'b1;
`ifdef GRID_SCHED_PAUSE_EN
  logic        pause = 1'b0;
`endif
  logic [1:0]  dir1 = 2'd0, dir2 = 2'd2;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata;
  logic [6:0]  pos1_col, pos2_col;
  logic [5:0]  pos1_row, pos2_row;
  logic        game_over, busy;
  logic [1:0]  winner;

  typedef struct packed {
    logic [12:0] addr;
    logic [1:0]  data;
  } wr_t;

  wr_t        sb[$];
  int         n_chk = 0, n_fail = 0, wr_cnt = 0;
  logic [1:0] mem [8192];

  grid_tick_scheduler #(.TICK_CYCLES(TICK), .COLS(80), .ROWS(60)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .reiniciar(reiniciar), .frame_blank(frame_blank),
`ifdef GRID_SCHED_PAUSE_EN
    .pause(pause),
`endif
    .dir1(dir1), .dir2(dir2), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pos1_col(pos1_col), .pos1_row(pos1_row), .pos2_col(pos2_col),
    .pos2_row(pos2_row), .game_over(game_over), .winner(winner), .busy(busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // grid RAM; while VGA owns the port the read data is junk
  always @(posedge CLOCK_50) begin
    if (mem_we && frame_blank) mem[mem_addr] <= mem_wdata;
    mem_rdata <= frame_blank ? mem[mem_addr] : 2'b11;
  end

  always @(negedge CLOCK_50) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      wr_cnt++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL grid_write: got addr %0d data %0d, required addr %0d data %0d",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.addr = 13'(a);
    w.data = 2'(d);
    sb.push_back(w);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 4800; i++) begin
      int r, c;
      r = i / 80;
      c = i % 80;
      push_wr(i, (r < 2 || r > 57 || c < 2 || c > 77) ? 3 : 0);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < 400) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk(name, int'(busy), int'(lvl));
  endtask

  task automatic wait_clear_end(input string name);
    int n;
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr === 13'd4799) && n < 6000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk(name, int'(mem_we === 1'b1 && mem_addr === 13'd4799), 1);
    chk("busy_on_last_clear", int'(busy), 1);
    @(negedge CLOCK_50);
    chk("busy_fall_after_clear", int'(busy), 0);
  endtask

  task automatic run_step(input int a1, input int a2, input bit stall, input string name);
    int bad, n;
    push_wr(a1, 1);
    push_wr(a2, 2);
    wait_busy(1'b1, {name, "_start"});
    if (stall) begin
      n = 0;
      while (!(mem_we === 1'b1 && mem_wdata === 2'd1) && n < 50) begin
        @(negedge CLOCK_50);
        n++;
      end
      chk({name, "_mark1_seen"}, int'(mem_we === 1'b1 && mem_wdata === 2'd1), 1);
      @(posedge CLOCK_50); #1 frame_blank = 1'b0;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge CLOCK_50);
        if (mem_we !== 1'b0 || busy !== 1'b1) bad++;
      end
      chk({name, "_stall_quiet"}, bad, 0);
      @(posedge CLOCK_50); #1 frame_blank = 1'b1;
    end
    wait_busy(1'b0, {name, "_end"});
  endtask

  initial begin
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_pos1_col", int'(pos1_col), 27);
    chk("rst_pos1_row", int'(pos1_row), 30);
    chk("rst_pos2_col", int'(pos2_col), 52);
    chk("rst_pos2_row", int'(pos2_row), 30);

    push_clear();
    @(posedge CLOCK_50); #1 reset = 1'b0;
    wait_clear_end("clear1_last_addr");
    chk("clear1_write_count", wr_cnt, 4800);
    chk("clear_cell_0", int'(mem[0]), 3);
    chk("clear_cell_162", int'(mem[162]), 0);
    chk("clear_cell_4799", int'(mem[4799]), 3);

`ifdef GRID_SCHED_PAUSE_EN
    begin
      int bad;
      @(posedge CLOCK_50); #1 pause = 1'b1;
      bad = 0;
      for (int k = 0; k < 3 * TICK; k++) begin
        @(negedge CLOCK_50);
        if (busy !== 1'b0 || mem_we !== 1'b0) bad++;
      end
      chk("pause_no_step", bad, 0);
      @(posedge CLOCK_50); #1 pause = 1'b0;
    end
`endif

    run_step(2427, 2452, 1'b0, "step1");
    chk("step1_pos1_col", int'(pos1_col), 28);
    chk("step1_pos2_col", int'(pos2_col), 51);
    chk("step1_pos1_row", int'(pos1_row), 30);
    run_step(2428, 2451, 1'b1, "step2_stall");
    chk("step2_pos1_col", int'(pos1_col), 29);
    chk("step2_pos2_col", int'(pos2_col), 50);
    for (int k = 3; k <= 12; k++) run_step(2426 + k, 2453 - k, 1'b0, "step");
    chk("step12_pos1_col", int'(pos1_col), 39);
    chk("step12_pos2_col", int'(pos2_col), 40);
    chk("step12_game_over", int'(game_over), 0);

    run_step(2439, 2440, 1'b0, "step13");
    chk("headon_game_over", int'(game_over), 1);
    chk("headon_winner", int'(winner), 3);
    chk("headon_pos1_col", int'(pos1_col), 39);
    chk("headon_pos2_col", int'(pos2_col), 40);

    repeat (3 * TICK) @(negedge CLOCK_50);
    chk("over_hold_game_over", int'(game_over), 1);
    chk("over_hold_winner", int'(winner), 3);
    chk("over_hold_pos1_col", int'(pos1_col), 39);

    push_clear();
    @(posedge CLOCK_50); #1 reiniciar = 1'b1;
    @(posedge CLOCK_50); #1 reiniciar = 1'b0;
    @(negedge CLOCK_50);
    chk("restart_busy", int'(busy), 1);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_winner", int'(winner), 0);
    chk("restart_pos1_col", int'(pos1_col), 27);
    wait_clear_end("clear2_last_addr");

    run_step(2427, 2452, 1'b0, "rev_step1");
    chk("rev_step1_pos1_col", int'(pos1_col), 28);
    dir1 = 2'd2;
    run_step(2428, 2451, 1'b0, "rev_step2");
    chk("rev_game_over", int'(game_over), 1);
    chk("rev_winner", int'(winner), 2);
    chk("rev_pos1_col", int'(pos1_col), 28);

    repeat (5) @(negedge CLOCK_50);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
